// File: rtl/cpu_bus_overlay.sv
// 6502 bus front end: arms on NMI, captures the vector fetch, then maps one page onto the control block port.
// Hit/ctrl_cs are combinational; phi2-qualified actions land 3 clk after the phi2 fall, read enable lags 1 clk.
module cpu_bus_overlay #(
    parameter logic [7:0]  OVERLAY_PAGE = 8'hFF,
    parameter logic [15:0] VECTOR_ADDR  = 16'hFFFA
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        phi2,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rw,
    input  logic        cpu_sync,
    input  logic [7:0]  cpu_dout,
    input  logic        nmi_n,
    input  logic [7:0]  ctrl_dout,
    output logic [7:0]  ctrl_addr,
    output logic        ctrl_cs,
    output logic        ctrl_write,
    output logic [7:0]  ctrl_din,
    output logic [7:0]  cpu_din,
    output logic        cpu_din_oe,
    output logic        ram_sel,
    output logic        overlay_active
);

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        ARMED   = 2'd1,
        OVERLAY = 2'd2
    } state_t;

    localparam logic [15:0] VECTOR_HI = VECTOR_ADDR + 16'd1;

    state_t state, state_nxt;
    logic   phi2_s1, phi2_s2, phi2_d;
    logic   phi2_hi, phi2_fall;
    logic   nmi_prev, nmi_fall;
    logic   hit;

    // phi2 is asynchronous to clk: two sync stages, then one stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phi2_s1  <= 1'b0;
            phi2_s2  <= 1'b0;
            phi2_d   <= 1'b0;
            nmi_prev <= 1'b1;
        end else begin
            phi2_s1  <= phi2;
            phi2_s2  <= phi2_s1;
            phi2_d   <= phi2_s2;
            nmi_prev <= nmi_n;
        end
    end

    assign phi2_hi   = phi2_s2;
    assign phi2_fall = phi2_d & ~phi2_s2;
    assign nmi_fall  = nmi_prev & ~nmi_n;

    always_comb begin
        hit = 1'b0;
        case (state)
            ARMED:   hit = (cpu_addr == VECTOR_ADDR) || (cpu_addr == VECTOR_HI);
            OVERLAY: hit = (cpu_addr[15:8] == OVERLAY_PAGE);
            default: hit = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            NORMAL: if (nmi_fall) state_nxt = ARMED;
            ARMED: begin
                if (phi2_fall && cpu_rw && (cpu_addr == VECTOR_HI))
                    state_nxt = OVERLAY;
            end
            OVERLAY: begin
                // only an opcode fetch outside the page releases it
                if (phi2_fall && cpu_sync && cpu_rw && (cpu_addr[15:8] != OVERLAY_PAGE))
                    state_nxt = NORMAL;
            end
            default: state_nxt = NORMAL;
        endcase
    end

    // strobes use the pre-transition hit, since state updates on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= NORMAL;
            overlay_active <= 1'b0;
            cpu_din_oe     <= 1'b0;
            ctrl_write     <= 1'b0;
            ctrl_din       <= 8'h00;
        end else begin
            state          <= state_nxt;
            overlay_active <= (state_nxt == OVERLAY);
            cpu_din_oe     <= hit & cpu_rw & phi2_hi;
            ctrl_write     <= phi2_fall & hit & ~cpu_rw;
            if (phi2_fall && hit && !cpu_rw)
                ctrl_din <= cpu_dout;
        end
    end

    assign ctrl_addr = cpu_addr[7:0];
    assign ctrl_cs   = hit;
    assign ram_sel   = ~hit;
    assign cpu_din   = ctrl_dout;

endmodule

// File: tb/tb_cpu_bus_overlay.sv
// Directed vector bench for cpu_bus_overlay: each record is one CPU bus cycle with expected outputs.
module tb_cpu_bus_overlay;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        phi2 = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic        cpu_rw = 1'b1;
    logic        cpu_sync = 1'b0;
    logic [7:0]  cpu_dout = 8'h00;
    logic        nmi_n = 1'b1;
    logic [7:0]  ctrl_dout = 8'h00;
    logic [7:0]  ctrl_addr;
    logic        ctrl_cs;
    logic        ctrl_write;
    logic [7:0]  ctrl_din;
    logic [7:0]  cpu_din;
    logic        cpu_din_oe;
    logic        ram_sel;
    logic        overlay_active;

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    logic [7:0] wr_dat = 8'h00;

    cpu_bus_overlay dut (
        .clk(clk), .rst_n(rst_n), .phi2(phi2), .cpu_addr(cpu_addr),
        .cpu_rw(cpu_rw), .cpu_sync(cpu_sync), .cpu_dout(cpu_dout),
        .nmi_n(nmi_n), .ctrl_dout(ctrl_dout), .ctrl_addr(ctrl_addr),
        .ctrl_cs(ctrl_cs), .ctrl_write(ctrl_write), .ctrl_din(ctrl_din),
        .cpu_din(cpu_din), .cpu_din_oe(cpu_din_oe), .ram_sel(ram_sel),
        .overlay_active(overlay_active)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ctrl_write) begin
            wr_cnt = wr_cnt + 1;
            wr_dat = ctrl_din;
        end
    end

    typedef struct {
        logic        nmi;
        logic [15:0] addr;
        logic        rw;
        logic        sync;
        logic [7:0]  wdat;
        logic [7:0]  rdat;
        logic        cs;
        logic        oe;
        int          wr;
        logic        ov;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s (vec %0d): got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_nmi();
        @(negedge clk);
        nmi_n = 1'b0;
        @(negedge clk);
        nmi_n = 1'b1;
        wait_clk(2);
    endtask

    task automatic apply(input vec_t v, input int idx);
        int w0;
        if (v.nmi) pulse_nmi();
        @(negedge clk);
        cpu_addr  = v.addr;
        cpu_rw    = v.rw;
        cpu_sync  = v.sync;
        cpu_dout  = v.wdat;
        ctrl_dout = v.rdat;
        w0 = wr_cnt;
        wait_clk(3);
        phi2 = 1'b1;
        wait_clk(6);
        chk("ctrl_cs", idx, {15'd0, ctrl_cs}, {15'd0, v.cs});
        chk("ram_sel", idx, {15'd0, ram_sel}, {15'd0, ~v.cs});
        chk("ctrl_addr", idx, {8'd0, ctrl_addr}, {8'd0, v.addr[7:0]});
        chk("cpu_din_oe", idx, {15'd0, cpu_din_oe}, {15'd0, v.oe});
        if (v.oe) chk("cpu_din", idx, {8'd0, cpu_din}, {8'd0, v.rdat});
        phi2 = 1'b0;
        wait_clk(8);
        chk("oe_after_fall", idx, {15'd0, cpu_din_oe}, 16'd0);
        chk("write_count", idx, 16'(wr_cnt - w0), 16'(v.wr));
        if (v.wr != 0) chk("ctrl_din", idx, {8'd0, wr_dat}, {8'd0, v.wdat});
        chk("overlay_active", idx, {15'd0, overlay_active}, {15'd0, v.ov});
    endtask

    initial begin
        //         nmi   addr      rw    sync  wdat   rdat   cs    oe    wr  ov
        vecs[0]  = '{1'b0, 16'hFFFA, 1'b1, 1'b0, 8'h00, 8'h11, 1'b0, 1'b0, 0, 1'b0};
        vecs[1]  = '{1'b1, 16'hFFFA, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 0, 1'b0};
        vecs[2]  = '{1'b0, 16'hFF20, 1'b1, 1'b0, 8'h00, 8'h77, 1'b0, 1'b0, 0, 1'b0};
        vecs[3]  = '{1'b1, 16'hFFFB, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b1, 0, 1'b1};
        vecs[4]  = '{1'b0, 16'hFFF0, 1'b0, 1'b0, 8'h5A, 8'h00, 1'b1, 1'b0, 1, 1'b1};
        vecs[5]  = '{1'b0, 16'h1234, 1'b0, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0, 0, 1'b1};
        vecs[6]  = '{1'b1, 16'hFF20, 1'b1, 1'b1, 8'h00, 8'h3C, 1'b1, 1'b1, 0, 1'b1};
        vecs[7]  = '{1'b0, 16'h0400, 1'b1, 1'b1, 8'h00, 8'h99, 1'b0, 1'b0, 0, 1'b0};
        vecs[8]  = '{1'b0, 16'hFFFA, 1'b1, 1'b0, 8'h00, 8'h42, 1'b0, 1'b0, 0, 1'b0};
        vecs[9]  = '{1'b1, 16'hFFFB, 1'b1, 1'b0, 8'h00, 8'hC3, 1'b1, 1'b1, 0, 1'b1};
        vecs[10] = '{1'b0, 16'hFF10, 1'b0, 1'b0, 8'h3C, 8'h00, 1'b1, 1'b0, 1, 1'b1};
        vecs[11] = '{1'b0, 16'h0400, 1'b0, 1'b1, 8'h81, 8'h00, 1'b0, 1'b0, 0, 1'b1};
        vecs[12] = '{1'b0, 16'hFFFA, 1'b1, 1'b0, 8'h00, 8'h55, 1'b0, 1'b0, 0, 1'b0};

        // reset state
        #1;
        chk("rst_overlay", 0, {15'd0, overlay_active}, 16'd0);
        chk("rst_ram_sel", 0, {15'd0, ram_sel}, 16'd1);
        chk("rst_ctrl_write", 0, {15'd0, ctrl_write}, 16'd0);
        chk("rst_oe", 0, {15'd0, cpu_din_oe}, 16'd0);
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(2);

        for (int i = 0; i < 12; i++) apply(vecs[i], i);

        // reset asserted while overlaid and mid-read of the page
        @(negedge clk);
        cpu_addr = 16'hFF00;
        cpu_rw   = 1'b1;
        cpu_sync = 1'b0;
        wait_clk(2);
        phi2 = 1'b1;
        wait_clk(6);
        chk("pre_rst_cs", 20, {15'd0, ctrl_cs}, 16'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_overlay", 20, {15'd0, overlay_active}, 16'd0);
        chk("midrst_ram_sel", 20, {15'd0, ram_sel}, 16'd1);
        chk("midrst_cs", 20, {15'd0, ctrl_cs}, 16'd0);
        chk("midrst_write", 20, {15'd0, ctrl_write}, 16'd0);
        chk("midrst_oe", 20, {15'd0, cpu_din_oe}, 16'd0);
        phi2 = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(4);
        chk("postrst_overlay", 21, {15'd0, overlay_active}, 16'd0);
        chk("postrst_cs", 21, {15'd0, ctrl_cs}, 16'd0);
        apply(vecs[12], 12);

        // re-enter overlay, then land an NMI fall on the same clk as the exit
        apply(vecs[9], 9);
        @(negedge clk);
        cpu_addr = 16'h0400;
        cpu_rw   = 1'b1;
        cpu_sync = 1'b1;
        wait_clk(3);
        phi2 = 1'b1;
        wait_clk(6);
        chk("exit_cs", 22, {15'd0, ctrl_cs}, 16'd0);
        phi2 = 1'b0;
        wait_clk(2);
        nmi_n = 1'b0;
        @(negedge clk);
        nmi_n = 1'b1;
        wait_clk(4);
        chk("exit_overlay", 22, {15'd0, overlay_active}, 16'd0);
        cpu_sync = 1'b0;
        // a dropped NMI leaves the vector unmapped
        apply(vecs[12], 23);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
